// File: rtl/pcs_rx_decode_fsm_if.sv
// Receive-side bundle between the 10-bit synchroniser and the GMII-facing logic.
// The master drives the codeword stream and counter clear. The slave (the PCS
// receive block) returns the decoded byte, the frame flags and the status.
interface pcs_rx_decode_fsm_if #(
  parameter int ERR_CNT_W = 16
);
  logic [9:0]           SUDI;
  logic                 sync_status;
  logic                 cnt_clr;
  logic [7:0]           RXD;
  logic                 RX_DV;
  logic                 RX_ER;
  logic [ERR_CNT_W-1:0] code_err_cnt;
  logic                 rd_pos;

  modport master (
    output SUDI, sync_status, cnt_clr,
    input  RXD, RX_DV, RX_ER, code_err_cnt, rd_pos
  );

  modport slave (
    input  SUDI, sync_status, cnt_clr,
    output RXD, RX_DV, RX_ER, code_err_cnt, rd_pos
  );
endinterface

// File: rtl/pcs_rx_decode_fsm.sv
// 1000BASE-X PCS receive block: 8B/10B decode with running-disparity check,
// a frame FSM that drives RXD/RX_DV/RX_ER, and a saturating code-violation
// counter. Every output is registered, so there is one cycle from codeword to
// output.
module pcs_rx_decode_fsm #(
  parameter int         ERR_CNT_W = 16,
  parameter bit         CHECK_RD  = 1'b1,
  parameter logic [7:0] SOP_BYTE  = 8'h55
) (
  input logic                CLK,
  input logic                RESET_N,
  pcs_rx_decode_fsm_if.slave rx
);
  localparam logic [9:0] K285_N = 10'b0011111010;
  localparam logic [9:0] K285_P = 10'b1100000101;
  localparam logic [9:0] S_N    = 10'b1101101000;
  localparam logic [9:0] S_P    = 10'b0010010111;
  localparam logic [9:0] T_N    = 10'b1011101000;
  localparam logic [9:0] T_P    = 10'b0100010111;
  localparam logic [9:0] R_N    = 10'b1110101000;
  localparam logic [9:0] R_P    = 10'b0001010111;

  typedef enum logic [6:0] {
    WAIT_FOR_K = 7'b0000001,
    RX_K       = 7'b0000010,
    IDLE_D     = 7'b0000100,
    RECEIVE    = 7'b0001000,
    RX_ERROR   = 7'b0010000,
    TRI_RRI    = 7'b0100000,
    TRR        = 7'b1000000
  } state_t;

  typedef struct packed {
    logic       ok;
    logic       is_k;
    logic       rd_out;
    logic [7:0] byte_val;
  } col_t;

  // Decode one codeword under an assumed starting RD. The result says whether
  // the word is legal in that column, whether it is a control code, the RD at
  // the end of the word, and the decoded byte (HGF EDCBA).
  function automatic col_t col_chk(input logic rd_in, input logic [9:0] w);
    logic [5:0] s6;
    logic [3:0] s4;
    logic [4:0] x;
    logic [2:0] y;
    logic [2:0] n6, n4;
    logic       ok6, ok4, k28, a7, p7, dok6, dok4, rm, re, a7_req, kx7;
    col_t       r;
    s6 = w[9:4];
    s4 = w[3:0];
    ok6 = 1'b1; k28 = 1'b0; x = 5'd0;
    case (s6)
      6'b100111, 6'b011000: x = 5'd0;
      6'b011101, 6'b100010: x = 5'd1;
      6'b101101, 6'b010010: x = 5'd2;
      6'b110001:            x = 5'd3;
      6'b110101, 6'b001010: x = 5'd4;
      6'b101001:            x = 5'd5;
      6'b011001:            x = 5'd6;
      6'b111000, 6'b000111: x = 5'd7;
      6'b111001, 6'b000110: x = 5'd8;
      6'b100101:            x = 5'd9;
      6'b010101:            x = 5'd10;
      6'b110100:            x = 5'd11;
      6'b001101:            x = 5'd12;
      6'b101100:            x = 5'd13;
      6'b011100:            x = 5'd14;
      6'b010111, 6'b101000: x = 5'd15;
      6'b011011, 6'b100100: x = 5'd16;
      6'b100011:            x = 5'd17;
      6'b010011:            x = 5'd18;
      6'b110010:            x = 5'd19;
      6'b001011:            x = 5'd20;
      6'b101010:            x = 5'd21;
      6'b011010:            x = 5'd22;
      6'b111010, 6'b000101: x = 5'd23;
      6'b110011, 6'b001100: x = 5'd24;
      6'b100110:            x = 5'd25;
      6'b010110:            x = 5'd26;
      6'b110110, 6'b001001: x = 5'd27;
      6'b001110:            x = 5'd28;
      6'b101110, 6'b010001: x = 5'd29;
      6'b011110, 6'b100001: x = 5'd30;
      6'b101011, 6'b010100: x = 5'd31;
      6'b001111, 6'b110000: begin x = 5'd28; k28 = 1'b1; end
      default:              ok6 = 1'b0;
    endcase
    ok4 = 1'b1; a7 = 1'b0; p7 = 1'b0; y = 3'd0;
    case (s4)
      4'b1011, 4'b0100: y = 3'd0;
      4'b1001:          y = 3'd1;
      4'b0101:          y = 3'd2;
      4'b1100, 4'b0011: y = 3'd3;
      4'b1101, 4'b0010: y = 3'd4;
      4'b1010:          y = 3'd5;
      4'b0110:          y = 3'd6;
      4'b1110, 4'b0001: begin y = 3'd7; p7 = 1'b1; end
      4'b0111, 4'b1000: begin y = 3'd7; a7 = 1'b1; end
      default:          ok4 = 1'b0;
    endcase
    n6 = 3'($countones(s6));
    n4 = 3'($countones(s4));
    // 111000/000111 are balanced but each is legal in one column only
    case (n6)
      3'd4:    begin dok6 = !rd_in; rm = 1'b1; end
      3'd2:    begin dok6 = rd_in;  rm = 1'b0; end
      3'd3:    begin
        dok6 = (s6 == 6'b111000) ? !rd_in : (s6 == 6'b000111) ? rd_in : 1'b1;
        rm   = rd_in;
      end
      default: begin dok6 = 1'b0; rm = rd_in; end
    endcase
    case (n4)
      3'd3:    begin dok4 = !rm; re = 1'b1; end
      3'd1:    begin dok4 = rm;  re = 1'b0; end
      3'd2:    begin
        dok4 = (s4 == 4'b1100) ? !rm : (s4 == 4'b0011) ? rm : 1'b1;
        re   = rm;
      end
      default: begin dok4 = 1'b0; re = rm; end
    endcase
    // D.x.7 uses the alternate form only where the primary would make a run of five
    a7_req = !k28 && (rm ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                         : (x == 5'd17 || x == 5'd18 || x == 5'd20));
    kx7    = !k28 && a7 && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30);
    r.ok       = ok6 && ok4 && dok6 && dok4 &&
                 (a7 ? (k28 || a7_req || kx7) : !(p7 && (k28 || a7_req)));
    r.is_k     = k28 || kx7;
    r.rd_out   = re;
    r.byte_val = {y, x};
    return r;
  endfunction

  state_t               state_q, state_n;
  logic                 rd_q, rd_n;
  logic [7:0]           rxd_q, rxd_n;
  logic                 dv_q, dv_n, er_q, er_n;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_n;

  col_t       col_neg_p0, col_pos_p0, col_cur_p0, col_alt_p0, col_sel_p0;
  logic       valid_p0, is_d_p0, is_k285_p0, is_s_p0, is_t_p0, is_r_p0;
  logic [3:0] ones_p0;

  // ---- stage p0: classify the incoming codeword against both RD columns ----
  assign col_neg_p0 = col_chk(1'b0, rx.SUDI);
  assign col_pos_p0 = col_chk(1'b1, rx.SUDI);
  assign col_cur_p0 = rd_q ? col_pos_p0 : col_neg_p0;
  assign col_alt_p0 = rd_q ? col_neg_p0 : col_pos_p0;
  assign col_sel_p0 = col_cur_p0.ok ? col_cur_p0 : col_alt_p0;
  assign valid_p0   = col_cur_p0.ok || (!CHECK_RD && col_alt_p0.ok);
  assign is_d_p0    = valid_p0 && !col_sel_p0.is_k;
  assign is_k285_p0 = valid_p0 && (rx.SUDI == K285_N || rx.SUDI == K285_P);
  assign is_s_p0    = valid_p0 && (rx.SUDI == S_N || rx.SUDI == S_P);
  assign is_t_p0    = valid_p0 && (rx.SUDI == T_N || rx.SUDI == T_P);
  assign is_r_p0    = valid_p0 && (rx.SUDI == R_N || rx.SUDI == R_P);
  assign ones_p0    = 4'($countones(rx.SUDI));

  // Next state and next registered outputs of the receive FSM
  always_comb begin
    state_n = state_q;
    rxd_n   = 8'h00;
    dv_n    = 1'b0;
    er_n    = 1'b0;
    if (!rx.sync_status) begin
      state_n = WAIT_FOR_K;
      er_n    = dv_q;
    end else begin
      case (state_q)
        WAIT_FOR_K: if (is_k285_p0) state_n = RX_K;
        RX_K:       state_n = is_d_p0 ? IDLE_D : WAIT_FOR_K;
        IDLE_D: begin
          if (is_k285_p0) state_n = RX_K;
          else if (is_s_p0) begin
            state_n = RECEIVE;
            rxd_n   = SOP_BYTE;
            dv_n    = 1'b1;
          end else state_n = WAIT_FOR_K;
        end
        RECEIVE, RX_ERROR: begin
          if (is_d_p0) begin
            state_n = RECEIVE;
            rxd_n   = col_sel_p0.byte_val;
            dv_n    = 1'b1;
          end else if (is_t_p0) begin
            state_n = TRI_RRI;
          end else if (is_k285_p0) begin
            state_n = RX_K;
            er_n    = 1'b1;
          end else begin
            state_n = RX_ERROR;
            dv_n    = 1'b1;
            er_n    = 1'b1;
          end
        end
        TRI_RRI:    state_n = is_r_p0 ? TRR : WAIT_FOR_K;
        TRR: begin
          if (is_r_p0) state_n = TRR;
          else if (is_k285_p0) state_n = RX_K;
          else state_n = WAIT_FOR_K;
        end
        default:    state_n = WAIT_FOR_K;
      endcase
    end
  end

  // Running disparity and saturating violation count for the next cycle
  always_comb begin
    rd_n  = rd_q;
    cnt_n = cnt_q;
    if (!rx.sync_status) rd_n = 1'b0;
    else if (valid_p0) rd_n = col_sel_p0.rd_out;
    else if (ones_p0 > 4'd5) rd_n = 1'b1;
    else if (ones_p0 < 4'd5) rd_n = 1'b0;
    if (rx.cnt_clr) cnt_n = '0;
    else if (rx.sync_status && !valid_p0 && cnt_q != {ERR_CNT_W{1'b1}})
      cnt_n = cnt_q + 1'b1;
  end

  // ---- stage p1: registered state and outputs ----
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= WAIT_FOR_K;
      rd_q    <= 1'b0;
      rxd_q   <= 8'h00;
      dv_q    <= 1'b0;
      er_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      rd_q    <= rd_n;
      rxd_q   <= rxd_n;
      dv_q    <= dv_n;
      er_q    <= er_n;
      cnt_q   <= cnt_n;
    end
  end

  assign rx.RXD          = rxd_q;
  assign rx.RX_DV        = dv_q;
  assign rx.RX_ER        = er_q;
  assign rx.code_err_cnt = cnt_q;
  assign rx.rd_pos       = rd_q;
endmodule

// File: tb/tb_pcs_rx_decode_fsm.sv
// Directed bench for pcs_rx_decode_fsm. Two instances see the same codeword
// stream: dut_a runs with strict RD checking and a 16-bit counter, and dut_b
// accepts either RD column and has a 2-bit counter.
module tb_pcs_rx_decode_fsm;
  localparam logic [9:0] K285_N = 10'b0011111010;
  localparam logic [9:0] K285_P = 10'b1100000101;
  localparam logic [9:0] S_N    = 10'b1101101000;
  localparam logic [9:0] S_P    = 10'b0010010111;
  localparam logic [9:0] T_N    = 10'b1011101000;
  localparam logic [9:0] T_P    = 10'b0100010111;
  localparam logic [9:0] R_N    = 10'b1110101000;
  localparam logic [9:0] R_P    = 10'b0001010111;
  localparam logic [9:0] D162_N = 10'b0110110101;
  localparam logic [9:0] D162_P = 10'b1001000101;
  localparam logic [9:0] D56    = 10'b1010010110;
  localparam logic [9:0] D00_N  = 10'b1001110100;
  localparam logic [9:0] D00_P  = 10'b0110001011;
  localparam logic [9:0] D10_N  = 10'b0111010100;
  localparam logic [9:0] D30_N  = 10'b1100011011;
  localparam logic [9:0] D70_N  = 10'b1110001011;
  localparam logic [9:0] BAD    = 10'b1111111111;

  logic       clk;
  logic       rst_n;
  logic [9:0] sudi;
  logic       sync;
  logic       clr;
  int         n_total;
  int         n_bad;

  pcs_rx_decode_fsm_if #(.ERR_CNT_W(16)) if_a ();
  pcs_rx_decode_fsm_if #(.ERR_CNT_W(2))  if_b ();

  assign if_a.SUDI        = sudi;
  assign if_a.sync_status = sync;
  assign if_a.cnt_clr     = clr;
  assign if_b.SUDI        = sudi;
  assign if_b.sync_status = sync;
  assign if_b.cnt_clr     = clr;

  pcs_rx_decode_fsm #(.ERR_CNT_W(16), .CHECK_RD(1'b1), .SOP_BYTE(8'h55)) dut_a (
    .CLK(clk), .RESET_N(rst_n), .rx(if_a)
  );
  pcs_rx_decode_fsm #(.ERR_CNT_W(2), .CHECK_RD(1'b0), .SOP_BYTE(8'h55)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .rx(if_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [9:0] w, input logic s, input logic c);
    sudi = w;
    sync = s;
    clr  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input string tag, input logic dv, input logic er, input logic [7:0] rxd);
    check_val({tag, "_a_dv"}, 32'(if_a.RX_DV), 32'(dv));
    check_val({tag, "_a_er"}, 32'(if_a.RX_ER), 32'(er));
    if (dv) check_val({tag, "_a_rxd"}, 32'(if_a.RXD), 32'(rxd));
  endtask

  task automatic expect_b(input string tag, input logic dv, input logic er, input logic [7:0] rxd);
    check_val({tag, "_b_dv"}, 32'(if_b.RX_DV), 32'(dv));
    check_val({tag, "_b_er"}, 32'(if_b.RX_ER), 32'(er));
    if (dv) check_val({tag, "_b_rxd"}, 32'(if_b.RXD), 32'(rxd));
  endtask

  task automatic expect_both(input string tag, input logic dv, input logic er, input logic [7:0] rxd);
    expect_a(tag, dv, er, rxd);
    expect_b(tag, dv, er, rxd);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    sudi    = K285_N;
    sync    = 1'b1;
    clr     = 1'b0;
    #12;
    check_val("rst_rxd", 32'(if_a.RXD), 32'h0);
    check_val("rst_dv", 32'(if_a.RX_DV), 32'h0);
    check_val("rst_er", 32'(if_a.RX_ER), 32'h0);
    check_val("rst_cnt", 32'(if_a.code_err_cnt), 32'h0);
    check_val("rst_rd", 32'(if_a.rd_pos), 32'h0);
    rst_n = 1'b1;

    // idle lock: K28.5 / D16.2 pairs
    step(K285_N, 1'b1, 1'b0);
    check_val("t1_rd_after_k", 32'(if_a.rd_pos), 32'h1);
    step(D162_P, 1'b1, 1'b0);
    step(K285_N, 1'b1, 1'b0);
    step(D162_P, 1'b1, 1'b0);
    expect_both("t1_idle", 1'b0, 1'b0, 8'h00);
    check_val("t1_cnt", 32'(if_a.code_err_cnt), 32'h0);
    check_val("t1_rd", 32'(if_a.rd_pos), 32'h0);

    // good frame
    step(S_N, 1'b1, 1'b0);    expect_both("t2_sop", 1'b1, 1'b0, 8'h55);
    step(D00_N, 1'b1, 1'b0);  expect_both("t2_d0", 1'b1, 1'b0, 8'h00);
    step(D10_N, 1'b1, 1'b0);  expect_both("t2_d1", 1'b1, 1'b0, 8'h01);
    step(D30_N, 1'b1, 1'b0);  expect_both("t2_d3", 1'b1, 1'b0, 8'h03);
    check_val("t2_rd_d3", 32'(if_a.rd_pos), 32'h1);
    step(T_P, 1'b1, 1'b0);    expect_both("t2_t", 1'b0, 1'b0, 8'h00);
    step(R_P, 1'b1, 1'b0);    expect_both("t2_r", 1'b0, 1'b0, 8'h00);
    step(K285_P, 1'b1, 1'b0); expect_both("t2_k", 1'b0, 1'b0, 8'h00);
    check_val("t2_rd_k", 32'(if_a.rd_pos), 32'h0);
    step(D56, 1'b1, 1'b0);    expect_both("t2_d56", 1'b0, 1'b0, 8'h00);

    // disparity error inside a frame
    step(S_N, 1'b1, 1'b0);    expect_both("t3_sop", 1'b1, 1'b0, 8'h55);
    step(D00_P, 1'b1, 1'b0);
    expect_a("t3_rderr", 1'b1, 1'b1, 8'h00);
    expect_b("t3_rdok", 1'b1, 1'b0, 8'h00);
    check_val("t3_cnt_a", 32'(if_a.code_err_cnt), 32'h1);
    check_val("t3_cnt_b", 32'(if_b.code_err_cnt), 32'h0);
    check_val("t3_rd_b", 32'(if_b.rd_pos), 32'h1);
    step(D56, 1'b1, 1'b0);    expect_both("t3_recover", 1'b1, 1'b0, 8'hC5);
    step(T_N, 1'b1, 1'b0);    expect_both("t3_t", 1'b0, 1'b0, 8'h00);
    check_val("t3_rd_b_t", 32'(if_b.rd_pos), 32'h0);
    step(R_N, 1'b1, 1'b0);
    step(K285_N, 1'b1, 1'b0);
    step(D162_P, 1'b1, 1'b0); expect_both("t3_idle", 1'b0, 1'b0, 8'h00);

    // early end on K28.5
    step(S_N, 1'b1, 1'b0);    expect_both("t4_sop", 1'b1, 1'b0, 8'h55);
    step(D70_N, 1'b1, 1'b0);  expect_both("t4_d7", 1'b1, 1'b0, 8'h07);
    step(K285_P, 1'b1, 1'b0); expect_both("t4_early", 1'b0, 1'b1, 8'h00);
    step(D56, 1'b1, 1'b0);    expect_both("t4_after", 1'b0, 1'b0, 8'h00);

    // sync loss mid-frame
    step(S_N, 1'b1, 1'b0);    expect_both("t5_sop", 1'b1, 1'b0, 8'h55);
    step(D00_N, 1'b1, 1'b0);  expect_both("t5_d0", 1'b1, 1'b0, 8'h00);
    step(D10_N, 1'b0, 1'b0);  expect_both("t5_loss", 1'b0, 1'b1, 8'h00);
    step(BAD, 1'b0, 1'b0);    expect_both("t5_loss2", 1'b0, 1'b0, 8'h00);
    check_val("t5_nocount", 32'(if_a.code_err_cnt), 32'h1);
    check_val("t5_rd", 32'(if_a.rd_pos), 32'h0);
    step(S_N, 1'b1, 1'b0);    expect_both("t5_nolock", 1'b0, 1'b0, 8'h00);
    step(K285_N, 1'b1, 1'b0);
    step(D162_P, 1'b1, 1'b0);
    step(S_N, 1'b1, 1'b0);    expect_both("t5_relock", 1'b1, 1'b0, 8'h55);
    step(T_N, 1'b1, 1'b0);    expect_both("t5_t", 1'b0, 1'b0, 8'h00);

    // counter saturation and clear
    step(BAD, 1'b1, 1'b0); check_val("t6_cnt_b1", 32'(if_b.code_err_cnt), 32'h1);
    check_val("t6_rd_bad", 32'(if_a.rd_pos), 32'h1);
    step(BAD, 1'b1, 1'b0); check_val("t6_cnt_b2", 32'(if_b.code_err_cnt), 32'h2);
    step(BAD, 1'b1, 1'b0); check_val("t6_cnt_b3", 32'(if_b.code_err_cnt), 32'h3);
    step(BAD, 1'b1, 1'b0); check_val("t6_cnt_b4", 32'(if_b.code_err_cnt), 32'h3);
    step(BAD, 1'b1, 1'b0); check_val("t6_cnt_b5", 32'(if_b.code_err_cnt), 32'h3);
    check_val("t6_cnt_a", 32'(if_a.code_err_cnt), 32'h6);
    step(BAD, 1'b1, 1'b1);
    check_val("t6_clr_a", 32'(if_a.code_err_cnt), 32'h0);
    check_val("t6_clr_b", 32'(if_b.code_err_cnt), 32'h0);

    // frame at RD+, then asynchronous reset mid-frame
    step(K285_P, 1'b1, 1'b0);
    step(D162_N, 1'b1, 1'b0);
    step(S_P, 1'b1, 1'b0);    expect_both("t6_sop_p", 1'b1, 1'b0, 8'h55);
    step(BAD, 1'b1, 1'b0);    expect_both("t6_err", 1'b1, 1'b1, 8'h00);
    step(D56, 1'b1, 1'b0);    expect_both("t6_d56", 1'b1, 1'b0, 8'hC5);
    check_val("t6_cnt_pre", 32'(if_a.code_err_cnt), 32'h1);
    check_val("t6_rd_pre", 32'(if_a.rd_pos), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_arst_dv", 32'(if_a.RX_DV), 32'h0);
    check_val("t6_arst_er", 32'(if_a.RX_ER), 32'h0);
    check_val("t6_arst_rxd", 32'(if_a.RXD), 32'h0);
    check_val("t6_arst_cnt", 32'(if_a.code_err_cnt), 32'h0);
    check_val("t6_arst_rd", 32'(if_a.rd_pos), 32'h0);
    check_val("t6_arst_dv_b", 32'(if_b.RX_DV), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
